// File: rtl/abb_count_monitor.sv
// Count monitor for the abb sequence counter: folds modulo-16 count deltas into a
// saturating total, with a sticky threshold flag, an interrupt pulse and a four-phase snapshot read.
module abb_count_monitor #(
  parameter int TOT_W     = 16,
  parameter bit CLR_ON_RD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cn_in,
  input  logic             src_clr,
  input  logic [TOT_W-1:0] threshold,
  input  logic             rd_req,
  output logic             evt,
  output logic [TOT_W-1:0] total,
  output logic             thr_hit,
  output logic             irq,
  output logic             ovf,
  output logic             rd_ack,
  output logic [TOT_W-1:0] rd_data
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rd_state_t;

  rd_state_t        state_r;
  logic [3:0]       cn_prev_r;
  logic [3:0]       delta_s;
  logic             accum_s;
  logic             capture_s;
  logic             clear_s;
  logic [TOT_W-1:0] base_total_s;
  logic             base_ovf_s;
  logic             base_thr_s;
  logic [TOT_W:0]   sum_s;
  logic [TOT_W-1:0] total_nxt_s;
  logic             ovf_nxt_s;
  logic             thr_nxt_s;

  // Saturating add of a 4-bit delta; bit TOT_W of the result flags saturation.
  function automatic logic [TOT_W:0] sat_add(input logic [TOT_W-1:0] a, input logic [3:0] d);
    logic [TOT_W:0] sum;
    sum = {1'b0, a} + {{(TOT_W-3){1'b0}}, d};
    if (sum[TOT_W]) begin
      sat_add = {1'b1, {TOT_W{1'b1}}};
    end else begin
      sat_add = {1'b0, sum[TOT_W-1:0]};
    end
  endfunction

  // Next-state computation for the total, overflow and threshold flags.
  always_comb begin
    delta_s   = cn_in - cn_prev_r;
    accum_s   = ~src_clr & (delta_s != 4'd0);
    capture_s = (state_r == ST_IDLE) & rd_req;
    clear_s   = capture_s & CLR_ON_RD;
    // A clearing read restarts from zero so this edge's delta is not lost.
    if (clear_s) begin
      base_total_s = {TOT_W{1'b0}};
      base_ovf_s   = 1'b0;
      base_thr_s   = 1'b0;
    end else begin
      base_total_s = total;
      base_ovf_s   = ovf;
      base_thr_s   = thr_hit;
    end
    sum_s = sat_add(base_total_s, delta_s);
    if (accum_s) begin
      total_nxt_s = sum_s[TOT_W-1:0];
      ovf_nxt_s   = base_ovf_s | sum_s[TOT_W];
    end else begin
      total_nxt_s = base_total_s;
      ovf_nxt_s   = base_ovf_s;
    end
    thr_nxt_s = base_thr_s |
                ((threshold != {TOT_W{1'b0}}) & (total_nxt_s >= threshold));
  end

  // Accumulator, event and threshold registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cn_prev_r <= 4'd0;
      evt       <= 1'b0;
      total     <= {TOT_W{1'b0}};
      ovf       <= 1'b0;
      thr_hit   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      cn_prev_r <= cn_in;
      evt       <= accum_s;
      total     <= total_nxt_s;
      ovf       <= ovf_nxt_s;
      thr_hit   <= thr_nxt_s;
      irq       <= thr_nxt_s & ~thr_hit;
    end
  end

  // Four-phase read handshake with snapshot capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      rd_ack  <= 1'b0;
      rd_data <= {TOT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rd_req) begin
            state_r <= ST_ACK;
            rd_ack  <= 1'b1;
            rd_data <= total;
          end else begin
            state_r <= ST_IDLE;
            rd_ack  <= 1'b0;
          end
        end
        ST_ACK: begin
          if (rd_req) begin
            state_r <= ST_ACK;
            rd_ack  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            rd_ack  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rd_ack  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abb_count_monitor.sv
// Self-checking bench: two monitors (TOT_W=16 and TOT_W=5) driven in parallel and
// compared every cycle against a rule-level model, plus hand-computed checkpoints.
module tb_abb_count_monitor;

  logic        clk;
  logic        reset;
  logic [3:0]  cn_in;
  logic        src_clr;
  logic [15:0] threshold;
  logic        rd_req;

  logic        evt_a, thr_a, irq_a, ovf_a, ack_a;
  logic [15:0] total_a, rdd_a;
  logic        evt_b, thr_b, irq_b, ovf_b, ack_b;
  logic [4:0]  total_b, rdd_b;

  int n_checks = 0;
  int n_fail   = 0;

  abb_count_monitor #(.TOT_W(16), .CLR_ON_RD(1'b1)) dut_a (
    .clk(clk), .reset(reset), .cn_in(cn_in), .src_clr(src_clr),
    .threshold(threshold), .rd_req(rd_req),
    .evt(evt_a), .total(total_a), .thr_hit(thr_a), .irq(irq_a),
    .ovf(ovf_a), .rd_ack(ack_a), .rd_data(rdd_a)
  );

  abb_count_monitor #(.TOT_W(5), .CLR_ON_RD(1'b1)) dut_b (
    .clk(clk), .reset(reset), .cn_in(cn_in), .src_clr(src_clr),
    .threshold(threshold[4:0]), .rd_req(rd_req),
    .evt(evt_b), .total(total_b), .thr_hit(thr_b), .irq(irq_b),
    .ovf(ovf_b), .rd_ack(ack_b), .rd_data(rdd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    int unsigned total;
    int unsigned rdd;
    int unsigned prev;
    bit          evt;
    bit          ovf;
    bit          thr;
    bit          irq;
    bit          ack;
  } mstate_t;

  mstate_t m [2];
  int unsigned maxv [2];

  initial begin
    maxv[0] = 32'd65535;
    maxv[1] = 32'd31;
  end

  function automatic mstate_t next_state(input mstate_t s, input int unsigned mx,
                                         input int unsigned cn, input bit clr,
                                         input bit rq, input int unsigned thr);
    mstate_t n;
    int unsigned d;
    bit acc;
    n   = s;
    d   = (cn + 32'd16 - s.prev) % 32'd16;
    acc = !clr && (d != 32'd0);
    n.prev = cn;
    n.evt  = acc;
    if (!s.ack && rq) begin
      n.rdd   = s.total;
      n.ack   = 1'b1;
      n.total = 32'd0;
      n.ovf   = 1'b0;
      n.thr   = 1'b0;
    end else if (s.ack && !rq) begin
      n.ack = 1'b0;
    end
    if (acc) begin
      if (n.total + d > mx) begin
        n.total = mx;
        n.ovf   = 1'b1;
      end else begin
        n.total = n.total + d;
      end
    end
    if (thr != 32'd0 && n.total >= thr) n.thr = 1'b1;
    n.irq = n.thr && !s.thr;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m[0] <= '0;
      m[1] <= '0;
    end else begin
      m[0] <= next_state(m[0], maxv[0], 32'(cn_in), src_clr, rd_req, 32'(threshold));
      m[1] <= next_state(m[1], maxv[1], 32'(cn_in), src_clr, rd_req, 32'(threshold[4:0]));
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("a.evt",     longint'(evt_a),   longint'(m[0].evt));
    check("a.total",   longint'(total_a), longint'(m[0].total));
    check("a.thr_hit", longint'(thr_a),   longint'(m[0].thr));
    check("a.irq",     longint'(irq_a),   longint'(m[0].irq));
    check("a.ovf",     longint'(ovf_a),   longint'(m[0].ovf));
    check("a.rd_ack",  longint'(ack_a),   longint'(m[0].ack));
    check("a.rd_data", longint'(rdd_a),   longint'(m[0].rdd));
    check("b.evt",     longint'(evt_b),   longint'(m[1].evt));
    check("b.total",   longint'(total_b), longint'(m[1].total));
    check("b.thr_hit", longint'(thr_b),   longint'(m[1].thr));
    check("b.irq",     longint'(irq_b),   longint'(m[1].irq));
    check("b.ovf",     longint'(ovf_b),   longint'(m[1].ovf));
    check("b.rd_ack",  longint'(ack_b),   longint'(m[1].ack));
    check("b.rd_data", longint'(rdd_b),   longint'(m[1].rdd));
  end

  task automatic step(input int cn, input bit clr, input bit rq);
    cn_in   = 4'(cn);
    src_clr = clr;
    rd_req  = rq;
    @(negedge clk);
  endtask

  task automatic do_reset(input int thr);
    reset     = 1'b0;
    cn_in     = 4'd0;
    src_clr   = 1'b0;
    rd_req    = 1'b0;
    threshold = 16'(thr);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int evt_cnt;
  int irq_cnt;
  longint t0;

  initial begin
    reset = 1'b0; cn_in = 4'd0; src_clr = 1'b0; threshold = 16'd0; rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset.total", longint'(total_a), 0);
    check("reset.rd_ack", longint'(ack_a), 0);
    check("reset.evt", longint'(evt_a), 0);
    reset = 1'b1;

    // Basic accumulate 0->1->2->3
    evt_cnt = 0;
    step(0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(i, 1'b0, 1'b0);
      evt_cnt += int'(evt_a);
    end
    check("basic.total", longint'(total_a), 3);
    check("basic.evt_cnt", longint'(evt_cnt), 3);
    check("basic.ovf", longint'(ovf_a), 0);

    // Wrap 14->15->0->1 and a 2->9 jump
    step(14, 1'b0, 1'b0);
    check("wrap.pre", longint'(total_a), 14);
    t0 = longint'(total_a);
    step(15, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0);
    check("wrap.delta", longint'(total_a) - t0, 3);
    step(2, 1'b0, 1'b0);
    t0 = longint'(total_a);
    step(9, 1'b0, 1'b0);
    check("jump.delta", longint'(total_a) - t0, 7);

    // Resync while upstream resets
    t0 = longint'(total_a);
    step(0, 1'b1, 1'b0);
    check("resync.total", longint'(total_a), t0);
    check("resync.evt", longint'(evt_a), 0);
    step(1, 1'b0, 1'b0);
    check("resync.next", longint'(total_a), t0 + 1);

    // Threshold at 5 with single irq
    do_reset(5);
    irq_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      step(i, 1'b0, 1'b0);
      irq_cnt += int'(irq_a);
    end
    check("thr.before", longint'(thr_a), 0);
    step(5, 1'b0, 1'b0);
    irq_cnt += int'(irq_a);
    check("thr.hit", longint'(thr_a), 1);
    check("thr.irq", longint'(irq_a), 1);
    check("thr.total", longint'(total_a), 5);
    step(6, 1'b0, 1'b0);
    irq_cnt += int'(irq_a);
    check("thr.irq_drop", longint'(irq_a), 0);
    check("thr.sticky", longint'(thr_a), 1);
    check("thr.irq_cnt", longint'(irq_cnt), 1);

    // Read capture concurrent with a +1 delta
    do_reset(0);
    step(10, 1'b0, 1'b0);
    check("rd.pre", longint'(total_a), 10);
    step(11, 1'b0, 1'b1);
    check("rd.data", longint'(rdd_a), 10);
    check("rd.total", longint'(total_a), 1);
    check("rd.ack", longint'(ack_a), 1);
    step(11, 1'b0, 1'b1);
    check("rd.ack_hold", longint'(ack_a), 1);
    step(11, 1'b0, 1'b0);
    check("rd.ack_drop", longint'(ack_a), 0);
    check("rd.data_hold", longint'(rdd_a), 10);
    step(11, 1'b0, 1'b1);
    check("rd.second", longint'(rdd_a), 1);
    check("rd.second_clr", longint'(total_a), 0);
    step(11, 1'b0, 1'b0);

    // Saturation on the narrow instance
    do_reset(0);
    for (int i = 1; i <= 35; i++) step(i % 16, 1'b0, 1'b0);
    check("sat.b_total", longint'(total_b), 31);
    check("sat.b_ovf", longint'(ovf_b), 1);
    check("sat.a_total", longint'(total_a), 35);
    check("sat.a_ovf", longint'(ovf_a), 0);
    step(4, 1'b0, 1'b0);
    check("sat.b_hold", longint'(total_b), 31);

    // Asynchronous reset mid-ACK
    step(4, 1'b0, 1'b1);
    check("mid.ack", longint'(ack_b), 1);
    check("mid.rdd", longint'(rdd_b), 31);
    #2 reset = 1'b0;
    #1;
    check("mid.ack_async", longint'(ack_a), 0);
    check("mid.total_async", longint'(total_a), 0);
    check("mid.rdd_async", longint'(rdd_b), 0);
    check("mid.ovf_async", longint'(ovf_b), 0);
    cn_in = 4'd0;
    @(negedge clk);
    reset = 1'b1;
    step(0, 1'b0, 1'b1);
    check("mid.idle_capture", longint'(ack_a), 1);
    step(0, 1'b0, 1'b0);
    check("mid.idle_release", longint'(ack_a), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/abb_count_monitor.md
# abb_count_monitor

Downstream consumer of the `abb` sequence counter's 4-bit running count. Each cycle it compares the count with the previous sample and folds the modulo-16 difference into a wide saturating total. It flags each count change, raises a sticky threshold flag with a one-cycle interrupt, and exposes a four-phase snapshot read port so software-side logic can collect totals without missing counter wrap-arounds.

## Interface
- `TOT_W`, 16: width of the accumulated total, threshold and read data; minimum 5.
- `CLR_ON_RD`, 1: when 1, a read capture clears `total`, `thr_hit` and `ovf`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately.
- `cn_in`  in  4  running count from the upstream counter, wraps 15→0.
- `src_clr`  in  1  high while the upstream counter is being reset; resynchronises without accumulating.
- `threshold`  in  TOT_W  compare level; 0 disables threshold detection.
- `rd_req`  in  1  read request, level, four-phase.
- `evt`  out  1  one-cycle pulse per observed count change.
- `total`  out  TOT_W  saturating accumulated count.
- `thr_hit`  out  1  sticky: `total` has reached `threshold`.
- `irq`  out  1  one-cycle pulse on the 0→1 transition of `thr_hit`.
- `ovf`  out  1  sticky: `total` saturated.
- `rd_ack`  out  1  read acknowledge.
- `rd_data`  out  TOT_W  snapshot of `total` taken at read capture.

## Operation
- **Reset values.** While `reset`=0, every output is 0, the internal `cn_prev` is 0, and the FSM is in IDLE.
- **Delta.** `delta = (cn_in - cn_prev) mod 16`, computed as a 4-bit subtraction and zero-extended to TOT_W.
- **Accumulate (`src_clr`=0, `delta`≠0).**
  - `cn_prev` ← `cn_in`; `evt` ← 1.
  - `total` ← `total + delta`. If the sum exceeds 2^TOT_W−1, `total` ← all-ones and `ovf` ← 1.
- **Resync (`src_clr`=1).** `cn_prev` ← `cn_in`; `total` is unchanged and `evt` ← 0. `src_clr` has priority over accumulate.
- **Threshold.**
  - `thr_hit` ← 1 when `threshold`≠0 and the next value of `total` ≥ `threshold`.
  - `irq` is 1 for exactly the cycle following the edge at which `thr_hit` goes 0→1.
  - Changing `threshold` never clears `thr_hit`.
- **Read FSM.** Two states, IDLE and ACK.
  - IDLE, `rd_req`=1 at an edge:
    - `rd_data` ← current (pre-update) `total`; state → ACK.
    - If CLR_ON_RD=1: `total` ← `delta` (or 0 if `src_clr`=1 or `delta`=0), and `ovf`, `thr_hit` ← 0 unless re-set by that same edge's update.
  - ACK: `rd_ack`=1. While `rd_req`=1, stay in ACK. When `rd_req`=0 at an edge, go to IDLE with `rd_ack`=0.
  - IDLE with `rd_req`=0: stay in IDLE.
- **Boundaries.**
  - Counter wrap 15→0 yields `delta`=1.
  - At saturation, further deltas leave `total` at all-ones.
  - `rd_data` holds its value until the next capture.
- **Reset mid-operation.** Asserting `reset` during ACK drops `rd_ack` asynchronously and returns the FSM to IDLE. Any in-flight read is abandoned.

## Timing
- **Accumulate latency.** `cn_in` change at edge k → `total`, `evt` updated after edge k (visible in cycle k+1).
- **`evt`.** One cycle wide. Back-to-back changes give back-to-back pulses.
- **Threshold latency.** `thr_hit` rises in the same cycle as the crossing `total`; `irq` rises in that same cycle and lasts one cycle.
- **Read handshake.**
  - `rd_req` sampled high at edge k → `rd_ack`=1 and `rd_data` valid from cycle k+1.
  - `rd_req` low at edge m → `rd_ack`=0 from cycle m+1.
  - The next capture is possible at edge m+1 at the earliest.
  - Minimum round trip is 2 cycles.
- **Reset release.** No output changes before the first rising edge after `reset` deasserts.
- **Registered outputs.** All outputs are registered; there is no combinational path from input to output.

## Test plan
- **Reset and basic accumulate.** Reset, then `cn_in` steps 0→1→2→3 on consecutive cycles → `total`=3, three `evt` pulses, `ovf`=0.
- **Wrap and multi-step delta.**
  - `cn_in` 14→15→0→1 → `total` grows by 3.
  - A jump 2→9 in one cycle → `delta`=7.
- **Resync.** `src_clr`=1 while `cn_in` 9→0 → `total` unchanged and no `evt`. Then 0→1 → `total`+1.
- **Threshold.** `threshold`=5, five increments → `thr_hit`=1 and a single `irq` pulse on the fifth update. A sixth increment gives no second `irq`.
- **Read with accumulate.**
  - CLR_ON_RD=1, `total`=10; assert `rd_req` on the same edge as a +1 delta → `rd_data`=10, `total`=1, `rd_ack`=1 next cycle.
  - Drop `rd_req` → `rd_ack`=0 the cycle after.
- **Saturation and async reset.**
  - TOT_W=5, push 35 increments → `total`=31, `ovf`=1.
  - Assert `reset` mid-ACK → all outputs 0 immediately, FSM in IDLE.
